// File: rtl/multibyte_serial_adder.sv
// Multi-byte serial adder: streams operand byte pairs LSB first through one
// 8-bit adder, ripples the inter-byte carry through a register, emits one
// registered sum byte per accepted pair and reports the final carry with done.

// Combinational 8-bit adder with carry in/out; the only arithmetic in the block.
module eight_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  // The 9-bit result splits into carry (MSB) and sum byte.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};

endmodule

module multibyte_serial_adder #(
  parameter int NUM_BYTES = 4  // operand width in bytes, 1..16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cin,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       out_valid,
  output logic [7:0] sum_byte,
  output logic [3:0] byte_idx,
  output logic       busy,
  output logic       done,
  output logic       carry_out
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Index of the most significant byte; a 4-bit counter covers up to 16 bytes.
  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  logic [1:0] state;
  logic       carry_reg;   // carry into the byte currently being accepted
  logic [3:0] count;       // index of the next byte to accept
  logic [7:0] byte_sum;
  logic       byte_carry;
  logic       accept;

  eight_bit_adder u_adder (
    .a  (a_byte),
    .b  (b_byte),
    .ci (carry_reg),
    .s  (byte_sum),
    .co (byte_carry)
  );

  // Handshake and status flags decoded directly from the state register.
  always_comb begin
    // NOTE: both outputs get a default before the case so that no state leaves
    // them unassigned, which would otherwise infer a latch.
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: busy = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_ready & in_valid;

  // Control FSM, carry ripple register and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      carry_reg <= 1'b0;
      count     <= 4'd0;
      out_valid <= 1'b0;
      sum_byte  <= 8'd0;
      byte_idx  <= 4'd0;
      done      <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values regardless of statement order.
      // out_valid and done are single-cycle pulses unless re-asserted below.
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            carry_reg <= cin;
            count     <= 4'd0;
            carry_out <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sum_byte  <= byte_sum;
            byte_idx  <= count;
            out_valid <= 1'b1;
            carry_reg <= byte_carry;
            count     <= count + 4'd1;
            // The last byte's carry is the overall carry; publish it with done
            // so it lines up with the final out_valid.
            if (count == LAST_IDX) begin
              done      <= 1'b1;
              carry_out <= byte_carry;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_serial_adder.sv
// Self-checking bench for multibyte_serial_adder: a whole-word reference model
// is compared against the 4-byte instance every cycle, directed scenarios pin
// literal results, and a 1-byte instance covers the single-byte case.
module tb_multibyte_serial_adder;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-byte instance
  logic       reset, start, cin, in_valid, in_ready;
  logic [7:0] a_byte, b_byte, sum_byte;
  logic       out_valid, busy, done, carry_out;
  logic [3:0] byte_idx;

  // 1-byte instance, driven independently
  logic       start1, cin1, in_valid1, in_ready1;
  logic [7:0] a1, b1, sum1;
  logic       out_valid1, busy1, done1, cout1;
  logic [3:0] idx1;

  multibyte_serial_adder #(.NUM_BYTES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_byte(a_byte), .b_byte(b_byte),
    .out_valid(out_valid), .sum_byte(sum_byte), .byte_idx(byte_idx),
    .busy(busy), .done(done), .carry_out(carry_out)
  );

  multibyte_serial_adder #(.NUM_BYTES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cin(cin1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a_byte(a1), .b_byte(b1),
    .out_valid(out_valid1), .sum_byte(sum1), .byte_idx(idx1),
    .busy(busy1), .done(done1), .carry_out(cout1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the whole sum is computed at start as one wide addition,
  // then handed out a byte at a time as the stimulus offers pairs.
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  int          m_phase;          // 0 idle, 1 taking bytes, 2 finishing
  int          m_k;
  logic [32:0] m_total;
  logic        e_valid, e_done, e_carry;
  logic [7:0]  e_sum;
  logic [3:0]  e_idx;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_k     <= 0;
      m_total <= '0;
      e_valid <= 1'b0;
      e_done  <= 1'b0;
      e_carry <= 1'b0;
      e_sum   <= 8'd0;
      e_idx   <= 4'd0;
    end else begin
      e_valid <= 1'b0;
      e_done  <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_k     <= 0;
          m_total <= {1'b0, op_a} + {1'b0, op_b} + 33'(cin);
          e_carry <= 1'b0;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          e_valid <= 1'b1;
          e_sum   <= m_total[8*m_k +: 8];
          e_idx   <= 4'(m_k);
          m_k     <= m_k + 1;
          if (m_k == N - 1) begin
            m_phase <= 2;
            e_done  <= 1'b1;
            e_carry <= m_total[32];
          end
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of what the DUT emitted.
  logic [7:0] got [16];
  int         done_count = 0;
  int         done_cyc   = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_out_valid", 64'(out_valid), 64'(e_valid));
      check("cmp_sum_byte",  64'(sum_byte),  64'(e_sum));
      check("cmp_byte_idx",  64'(byte_idx),  64'(e_idx));
      check("cmp_done",      64'(done),      64'(e_done));
      check("cmp_carry_out", 64'(carry_out), 64'(e_carry));
      check("cmp_in_ready",  64'(in_ready),  64'(m_phase == 1));
      check("cmp_busy",      64'(busy),      64'(m_phase != 0));
    end
    if (out_valid === 1'b1) got[byte_idx] <= sum_byte;
    if (done === 1'b1) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
  end

  task automatic clear_log();
    for (int i = 0; i < 16; i++) got[i] = 'x;
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_byte0"}, 64'(got[0]), 64'(e0));
    check({tag, "_byte1"}, 64'(got[1]), 64'(e1));
    check({tag, "_byte2"}, 64'(got[2]), 64'(e2));
    check({tag, "_byte3"}, 64'(got[3]), 64'(e3));
  endtask

  // One full addition on the 4-byte instance. gappy drops in_valid for a cycle
  // before every pair; pulse_k >= 0 raises start alongside byte pulse_k and
  // again (with in_valid) in the cycle after the last byte.
  task automatic do_add(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit gappy, input int pulse_k, output int t0);
    op_a = a;
    op_b = b;
    step();
    start    = 1'b1;
    cin      = c;
    in_valid = !gappy;
    a_byte   = a[7:0];
    b_byte   = b[7:0];
    t0       = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gappy) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      a_byte   = a[8*k +: 8];
      b_byte   = b[8*k +: 8];
      start    = (k == pulse_k);
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (pulse_k >= 0) begin
      start    = 1'b1;
      in_valid = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  // Watchdog: the scenarios are finite, so this only fires on a simulator hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int d0;
    reset = 1'b1; start = 1'b0; cin = 1'b0; in_valid = 1'b0;
    a_byte = 8'd0; b_byte = 8'd0;
    start1 = 1'b0; cin1 = 1'b0; in_valid1 = 1'b0; a1 = 8'd0; b1 = 8'd0;
    clear_log();
    repeat (2) step();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum_byte",  64'(sum_byte),  64'(0));
    check("rst_byte_idx",  64'(byte_idx),  64'(0));
    check("rst_done",      64'(done),      64'(0));
    check("rst_carry_out", 64'(carry_out), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst1_busy",     64'(busy1),     64'(0));
    cmp_en = 1'b1;
    reset  = 1'b0;
    step();

    // 1: 0xC8 + 0xC8, continuous in_valid
    clear_log();
    d0 = done_count;
    do_add(32'h0000_00C8, 32'h0000_00C8, 1'b0, 1'b0, -1, t0);
    repeat (3) step();
    check("t1_model", 64'(m_total), 64'(33'h0_0000_0190));
    check_bytes("t1", 8'h90, 8'h01, 8'h00, 8'h00);
    check("t1_carry", 64'(carry_out), 64'(0));
    check("t1_done_count", 64'(done_count - d0), 64'(1));
    check("t1_latency", 64'(done_cyc - t0), 64'(5));

    // 2: all-ones plus carry-in ripples through every byte
    clear_log();
    d0 = done_count;
    do_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, -1, t0);
    repeat (3) step();
    check("t2_model", 64'(m_total), 64'(33'h1_0000_0000));
    check_bytes("t2", 8'h00, 8'h00, 8'h00, 8'h00);
    check("t2_carry_held", 64'(carry_out), 64'(1));
    check("t2_done_count", 64'(done_count - d0), 64'(1));
    check("t2_latency", 64'(done_cyc - t0), 64'(5));

    // 3: bubbles on in_valid between pairs
    clear_log();
    d0 = done_count;
    do_add(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, -1, t0);
    repeat (3) step();
    check_bytes("t3", 8'h8A, 8'h67, 8'h45, 8'h23);
    check("t3_carry", 64'(carry_out), 64'(0));
    check("t3_done_count", 64'(done_count - d0), 64'(1));

    // 4: reset after byte 1 is accepted aborts the operation
    op_a = 32'h0000_00C8;
    op_b = 32'h0000_00C8;
    step();
    start = 1'b1; cin = 1'b0; in_valid = 1'b1;
    a_byte = 8'hC8; b_byte = 8'hC8;
    step();
    start = 1'b0;
    step();
    a_byte = 8'h00; b_byte = 8'h00;
    step();
    reset = 1'b1; in_valid = 1'b0;
    d0 = done_count;
    step();
    reset = 1'b0;
    check("t4_out_valid", 64'(out_valid), 64'(0));
    check("t4_sum_byte",  64'(sum_byte),  64'(0));
    check("t4_byte_idx",  64'(byte_idx),  64'(0));
    check("t4_busy",      64'(busy),      64'(0));
    check("t4_in_ready",  64'(in_ready),  64'(0));
    check("t4_carry_out", 64'(carry_out), 64'(0));
    repeat (4) step();
    check("t4_no_done", 64'(done_count - d0), 64'(0));
    clear_log();
    d0 = done_count;
    do_add(32'h0000_00C8, 32'h0000_00C8, 1'b0, 1'b0, -1, t0);
    repeat (3) step();
    check_bytes("t4_fresh", 8'h90, 8'h01, 8'h00, 8'h00);
    check("t4_fresh_latency", 64'(done_cyc - t0), 64'(5));

    // 5: in_valid in IDLE, start in RUN and DONE are all ignored
    in_valid = 1'b1; a_byte = 8'hAA; b_byte = 8'h55;
    repeat (3) step();
    in_valid = 1'b0;
    check("t5_idle_busy", 64'(busy), 64'(0));
    clear_log();
    d0 = done_count;
    do_add(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, 2, t0);
    repeat (3) step();
    check_bytes("t5", 8'h44, 8'h33, 8'h22, 8'h11);
    check("t5_done_count", 64'(done_count - d0), 64'(1));
    check("t5_latency", 64'(done_cyc - t0), 64'(5));
    check("t5_idle_after", 64'(busy), 64'(0));

    // 6: single-byte instance, 0x64 + 0x64 + 1
    step();
    start1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1; a1 = 8'h64; b1 = 8'h64;
    t0 = cyc;
    step();
    start1 = 1'b0;
    step();
    check("t6_out_valid", 64'(out_valid1), 64'(1));
    check("t6_sum",       64'(sum1),       64'(8'hC9));
    check("t6_idx",       64'(idx1),       64'(0));
    check("t6_done",      64'(done1),      64'(1));
    check("t6_carry",     64'(cout1),      64'(0));
    check("t6_in_ready",  64'(in_ready1),  64'(0));
    check("t6_latency",   64'(cyc - t0),   64'(2));
    in_valid1 = 1'b0;
    step();
    check("t6_done_pulse", 64'(done1), 64'(0));
    step();
    check("t6_idle", 64'(busy1), 64'(0));

    // 6b: single byte with carry out, 0xFF + 0x01
    start1 = 1'b1; cin1 = 1'b0; in_valid1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
    step();
    start1 = 1'b0;
    step();
    in_valid1 = 1'b0;
    check("t6b_sum",   64'(sum1),  64'(8'h00));
    check("t6b_carry", 64'(cout1), 64'(1));
    check("t6b_done",  64'(done1), 64'(1));
    repeat (2) step();
    check("t6b_carry_held", 64'(cout1), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
